req_arbiter: RTL and testbench



---
 rtl/req_arbiter_if.sv | 34 +++
 rtl/req_arbiter.sv | 136 +++++++++++++
 tb/tb_req_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/req_arbiter_if.sv
// rtl/req_arbiter_if.sv - request/grant handshake bundle between requesters, arbiter and encoder consumer
//
// Purpose : groups the arbiter's request, grant and status signals into one interface.
// Signals : req_in    [7:0] request strobes from the requesters
//           gnt_ack         consumer has taken the presented grant
//           gnt_valid       a grant is being presented
//           dout_gnt  [7:0] one-hot grant, bit 0 -> encoder input a ... bit 7 -> input h
//           pend_out  [7:0] pending-request register, status/debug
// Modports: master - requester/consumer side (drives req_in, gnt_ack)
//           slave  - arbiter side (drives gnt_valid, dout_gnt, pend_out)

interface req_arbiter_if;
   logic [7:0] req_in;
   logic       gnt_ack;
   logic       gnt_valid;
   logic [7:0] dout_gnt;
   logic [7:0] pend_out;

   modport master (
      output req_in,
      output gnt_ack,
      input  gnt_valid,
      input  dout_gnt,
      input  pend_out
   );

   modport slave (
      input  req_in,
      input  gnt_ack,
      output gnt_valid,
      output dout_gnt,
      output pend_out
   );
endinterface

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - eight-way request arbiter issuing registered one-hot grants to the 8-to-3 encoder
//
// Purpose : captures single-cycle request strobes into a pending register and presents one
//           registered one-hot grant at a time, held until acknowledged. One idle cycle always
//           separates consecutive grants.
// Ports   : clk - system clock, rising edge
//           rst - asynchronous active-high reset
//           bus - req_arbiter_if.slave (req_in, gnt_ack in; gnt_valid, dout_gnt, pend_out out)
// Config  : ARB_ROUND_ROBIN_EN defined   -> search starts at a rotating pointer (round robin)
//           ARB_ROUND_ROBIN_EN undefined -> search always starts at bit 0 (fixed priority)

module req_arbiter #(
   parameter int N_REQ = 8
) (
   input  logic          clk,
   input  logic          rst,
   req_arbiter_if.slave  bus
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_pending;
   logic [7:0] w_pending_nxt;
   logic [7:0] r_gnt;
   logic [7:0] w_gnt_nxt;
   logic [7:0] w_cand;
   logic [7:0] w_sel;
   logic [7:0] w_clr;
   logic [2:0] w_start;
   logic [2:0] w_try;
   logic       w_found;

`ifdef ARB_ROUND_ROBIN_EN
   logic [2:0] r_ptr;
   logic [2:0] w_ptr_nxt;
   logic [2:0] r_gnt_idx;
   logic [2:0] w_gnt_idx_nxt;
   logic [2:0] w_sel_idx;
   assign w_start = r_ptr;
`else
   assign w_start = 3'd0;
`endif

   // Requests arriving this cycle take part in arbitration immediately,
   // giving one-cycle request-to-grant latency.
   assign w_cand = r_pending | bus.req_in;

   // First set bit of w_cand searching upward from w_start; the 3-bit
   // add wraps 7 -> 0 on its own.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_try   = '0;
`ifdef ARB_ROUND_ROBIN_EN
      w_sel_idx = '0;
`endif
      for (int i = 0; i < N_REQ; i++) begin
         w_try = w_start + 3'(i);
         if (!w_found && w_cand[w_try]) begin
            w_found        = 1'b1;
            w_sel[w_try]   = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            w_sel_idx      = w_try;
`endif
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_clr       = '0;
`ifdef ARB_ROUND_ROBIN_EN
      w_ptr_nxt     = r_ptr;
      w_gnt_idx_nxt = r_gnt_idx;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_GRANT;
               w_gnt_nxt   = w_sel;
`ifdef ARB_ROUND_ROBIN_EN
               w_gnt_idx_nxt = w_sel_idx;
`endif
            end
         end
         S_GRANT: begin
            if (bus.gnt_ack) begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = '0;
               w_clr       = r_gnt;
`ifdef ARB_ROUND_ROBIN_EN
               w_ptr_nxt   = r_gnt_idx + 3'd1;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
      // OR-ing req_in after the clear lets a same-cycle re-request survive its own ack.
      w_pending_nxt = (r_pending & ~w_clr) | bus.req_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_pending <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_ptr     <= '0;
         r_gnt_idx <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_pending <= w_pending_nxt;
`ifdef ARB_ROUND_ROBIN_EN
         r_ptr     <= w_ptr_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
`endif
      end
   end

   // Every output comes straight from a register; gnt_valid is the OR of the one-hot grant.
   assign bus.dout_gnt  = r_gnt;
   assign bus.gnt_valid = |r_gnt;
   assign bus.pend_out  = r_pending;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - self-checking bench for req_arbiter (vector table, directed sequences, random vs model)

module tb_req_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   req_arbiter_if bus ();

   req_arbiter #(.N_REQ(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: set of pending requesters, busy flag, granted index, search start.
   bit m_pend [8];
   bit m_busy;
   int m_gidx;
   int m_ptr;

   typedef struct {
      logic [7:0] req;
      logic       ack;
      logic [7:0] exp_gnt;
      logic       exp_valid;
      logic [7:0] exp_pend;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_pend();
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = m_pend[i];
      return p;
   endfunction

   function automatic logic [7:0] model_gnt();
      logic [7:0] g;
      g = '0;
      if (m_busy) g[m_gidx] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_busy = 1'b0;
      m_gidx = 0;
      m_ptr  = 0;
   endtask

   task automatic model_edge(input logic [7:0] req, input logic ack);
      bit cand [8];
      for (int i = 0; i < 8; i++) cand[i] = m_pend[i] | req[i];
      if (m_busy) begin
         if (ack) begin
            m_pend[m_gidx] = 1'b0;
            m_busy = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            m_ptr = (m_gidx + 1) % 8;
`endif
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (!m_busy && cand[(m_ptr + k) % 8]) begin
               m_busy = 1'b1;
               m_gidx = (m_ptr + k) % 8;
            end
         end
      end
      for (int i = 0; i < 8; i++) if (req[i]) m_pend[i] = 1'b1;
   endtask

   // Called just after a falling edge: drive, let one rising edge pass, return at next falling edge.
   task automatic tick(input logic [7:0] req, input logic ack);
      bus.req_in  = req;
      bus.gnt_ack = ack;
      @(posedge clk);
      model_edge(req, ack);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_in  = '0;
      bus.gnt_ack = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_gnt"},   bus.dout_gnt,  model_gnt());
      check({tag, "_valid"}, bus.gnt_valid, m_busy);
      check({tag, "_pend"},  bus.pend_out,  model_pend());
      check({tag, "_onehot"}, $onehot0(bus.dout_gnt), 1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.req_in  = '0;
      bus.gnt_ack = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      check("reset_gnt",   bus.dout_gnt,  8'h00);
      check("reset_valid", bus.gnt_valid, 1'b0);
      check("reset_pend",  bus.pend_out,  8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Vector table: single request, hold, ack, ignored ack, same-cycle re-request, ack-in-idle.
      vecs[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[1]  = '{8'h10, 1'b0, 8'h10, 1'b1, 8'h10};
      vecs[2]  = '{8'h00, 1'b0, 8'h10, 1'b1, 8'h10};
      vecs[3]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      vecs[4]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      vecs[5]  = '{8'h04, 1'b0, 8'h04, 1'b1, 8'h04};
      vecs[6]  = '{8'h04, 1'b1, 8'h00, 1'b0, 8'h04};
      vecs[7]  = '{8'h00, 1'b0, 8'h04, 1'b1, 8'h04};
      vecs[8]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      vecs[9]  = '{8'h03, 1'b1, 8'h01, 1'b1, 8'h03};
      vecs[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h02};
      vecs[11] = '{8'h00, 1'b1, 8'h02, 1'b1, 8'h02};
      vecs[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      for (int v = 0; v < 13; v++) begin
         tick(vecs[v].req, vecs[v].ack);
         check($sformatf("vec%0d_gnt", v),   bus.dout_gnt,  vecs[v].exp_gnt);
         check($sformatf("vec%0d_valid", v), bus.gnt_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d_pend", v),  bus.pend_out,  vecs[v].exp_pend);
      end

      // Sweep: strobe FF once, ack held high; grants 01..80 on alternate cycles, then quiet.
      do_reset();
      for (int k = 0; k < 18; k++) begin
         logic [7:0] exp_g;
         exp_g = ((k % 2) == 0 && k < 16) ? 8'(1 << (k / 2)) : 8'h00;
         tick((k == 0) ? 8'hFF : 8'h00, 1'b1);
         check($sformatf("sweep%0d_gnt", k), bus.dout_gnt, exp_g);
         check($sformatf("sweep%0d_valid", k), bus.gnt_valid, exp_g != 0);
      end

      // Wrap-around: grant bit 6, ack, then strobe 41 -> 01 then 40.
      do_reset();
      tick(8'h40, 1'b0); check("wrap_g6",  bus.dout_gnt, 8'h40);
      tick(8'h00, 1'b1); check("wrap_rel", bus.gnt_valid, 1'b0);
      tick(8'h41, 1'b0); check("wrap_g0",  bus.dout_gnt, 8'h01);
      check("wrap_pend", bus.pend_out, 8'h41);
      tick(8'h00, 1'b1); check("wrap_gap", bus.dout_gnt, 8'h00);
      tick(8'h00, 1'b0); check("wrap_g6b", bus.dout_gnt, 8'h40);
      tick(8'h00, 1'b1); check("wrap_end", bus.pend_out, 8'h00);

`ifdef ARB_ROUND_ROBIN_EN
      // Round robin: FF then continuous 01 still rotates through every requester.
      do_reset();
      tick(8'hFF, 1'b1); check("rr_first", bus.dout_gnt, 8'h01);
      tick(8'h01, 1'b1);
      tick(8'h01, 1'b1); check("rr_second", bus.dout_gnt, 8'h02);
`else
      // Fixed priority: FF then continuous 01 strobes -> bit 0 wins every opportunity.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         tick((k == 0) ? 8'hFF : 8'h01, 1'b1);
         check($sformatf("fp%0d_gnt", k), bus.dout_gnt, ((k % 2) == 0) ? 8'h01 : 8'h00);
      end
      check("fp_starve_pend", bus.pend_out, 8'hFF);
`endif

      // Asynchronous reset in the middle of a grant.
      do_reset();
      tick(8'h20, 1'b0);
      check("arst_pre", bus.dout_gnt, 8'h20);
      #2 rst = 1'b1;
      #1;
      check("arst_gnt",   bus.dout_gnt,  8'h00);
      check("arst_valid", bus.gnt_valid, 1'b0);
      check("arst_pend",  bus.pend_out,  8'h00);
      bus.req_in = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      check("arst_hold_gnt",  bus.dout_gnt, 8'h00);
      check("arst_hold_pend", bus.pend_out, 8'h00);
      bus.req_in = 8'h00;
      rst = 1'b0;
      model_reset();

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         tick(r, 1'($urandom_range(0, 1)));
         check_model($sformatf("rnd%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
